bcd_scan_disp: RTL
==================

// Module: bcd_scan_disp
// PURPOSE
//   Downstream consumer of the cascaded decade counters. Takes their packed BCD
//   digits and drives a time-multiplexed common-anode 7-segment display: refresh
//   prescaler, digit scan, per-frame snapshot, leading-zero blanking and segment decode.
// PARAMETERS
//   DIGITS       4      number of BCD digits / anodes scanned (>=2)
//   REFRESH_DIV  50000  clk cycles each digit is held (>=1)
// PORTS
//   clk      in   1           system clock, all state on posedge
//   r        in   1           synchronous active-high reset
//   bcd_in   in   4*DIGITS    packed BCD, digit k = bcd_in[4k+3:4k], digit 0 = LS
//   dp_in    in   DIGITS      decimal point request per digit, 1 = lit
//   blank_lz in   1           1 = blank leading zeros
//   an       out  DIGITS      anode enables, active-low, one-hot-zero
//   seg      out  7           {g,f,e,d,c,b,a}, active-low
//   dp       out  1           decimal point, active-low
//   frame    out  1           one-cycle pulse, new snapshot taken
// BEHAVIOUR
//   Reset (r=1 at edge): cnt=0, idx=0, snap=0, an=all 1, seg=7'h7F, dp=1, frame=0.
//   Prescaler: cnt counts 0..REFRESH_DIV-1; tick = (cnt==REFRESH_DIV-1); on tick cnt->0.
//   REFRESH_DIV=1: tick every cycle. cnt width = clog2(REFRESH_DIV), min 1.
//   Scan: on tick idx -> idx+1, wrapping DIGITS-1 -> 0. Order is 0,1,..,DIGITS-1.
//   Snapshot: on tick with idx==DIGITS-1, snap <= bcd_in and dp_snap <= dp_in.
//   frame goes high for exactly the next cycle. Inputs are sampled only then.
//   Input changes mid-frame are never visible.
//   Outputs are registered from (idx, snap): an/seg/dp change 1 cycle after idx changes.
//   Each digit is held REFRESH_DIV cycles. Frame period = DIGITS*REFRESH_DIV.
//   an: bit idx = 0, all others 1.
//   Decode (active-high, then inverted onto seg): 0:3F 1:06 2:5B 3:4F 4:66 5:6D
//     6:7D 7:07 8:7F 9:6F; codes 10..15: 40 ('-').
//   LZB: when blank_lz=1, digit k (k>=1) is blanked (seg=7'h7F) if digits k..DIGITS-1
//     are all 4'h0. Digit 0 is never blanked. Codes 10..15 count as non-zero.
//   dp = ~dp_snap[idx]; it is independent of blanking.
//   blank_lz is used combinationally at output-register update; it is not snapshotted.
//   Reset mid-frame: next cycle outputs go to reset values. Scan restarts at digit 0
//     with snap=0; the first frame after reset shows "0" (plus blanked/zero digits).
//   First output after reset release: an selects digit 0, one cycle after release.
// TESTING (DIGITS=4, REFRESH_DIV=4)
//   1 r=1 3 cycles -> an=4'hF, seg=7'h7F, dp=1, frame=0. Release -> an=4'hE next cycle.
//     an stays 4'hE for 4 cycles.
//   2 bcd_in=16'h1234, dp_in=4'b0100, blank_lz=0; after 1st frame -> an E,D,B,7 each 4 cycles.
//     seg 19,30,24,79. dp=0 only while an=B. frame pulses every 16 cycles.
//   3 Change bcd_in 1234->9876 mid-frame -> displayed digits stay 1234 until the cycle
//     after the next frame pulse, then show 9876.
//   4 blank_lz=1: bcd_in=16'h0050 -> digits 3,2 seg=7F, digit1 seg=12, digit0 seg=40.
//     bcd_in=16'h0000 -> only digit 0 lit (40). blank_lz=0 -> all four show 40.
//   5 bcd_in=16'h00A0, blank_lz=1 -> digit1 seg=3F ('-'), digits 3,2 blanked, digit0 40.
//   6 Assert r while an=B mid-hold -> next cycle reset values. After release: idx=0,
//     snap=0, digit0 shows 40, frame pulse 16 cycles later.

Source files
------------

// File: rtl/bcd_scan_disp.sv
// Time-multiplexed common-anode 7-segment driver for packed BCD digits.
// Takes a per-frame snapshot of the digits and applies leading-zero blanking.
module bcd_scan_disp #(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  r,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
        case (digit)
            4'h0:    seg7_decode = 7'h3F;
            4'h1:    seg7_decode = 7'h06;
            4'h2:    seg7_decode = 7'h5B;
            4'h3:    seg7_decode = 7'h4F;
            4'h4:    seg7_decode = 7'h66;
            4'h5:    seg7_decode = 7'h6D;
            4'h6:    seg7_decode = 7'h7D;
            4'h7:    seg7_decode = 7'h07;
            4'h8:    seg7_decode = 7'h7F;
            4'h9:    seg7_decode = 7'h6F;
            default: seg7_decode = 7'h40;
        endcase
    endfunction

    logic [CW-1:0]        cnt_r;
    logic [IW-1:0]        idx_r;
    logic [4*DIGITS-1:0]  snap_r;
    logic [DIGITS-1:0]    dp_snap_r;
    logic [DIGITS-1:0]    an_r;
    logic [6:0]           seg_r;
    logic                 dp_r;
    logic                 frame_r;

    logic                 tick_s;
    logic                 last_s;
    logic [3:0]           cur_digit_s;
    logic                 cur_dp_s;
    logic                 cur_blank_s;
    logic                 zero_run_s;
    logic [DIGITS-1:0]    an_s;

    // Select the scanned digit; zero_run_s tracks "this digit and all above are zero".
    always_comb begin
        tick_s      = (cnt_r == CNT_MAX);
        last_s      = (idx_r == IDX_MAX);
        cur_digit_s = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b0;
        zero_run_s  = 1'b1;
        an_s        = {DIGITS{1'b1}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run_s  = zero_run_s & (snap_r[4*k +: 4] == 4'h0);
            an_s[k]     = (idx_r != IW'(k));
            cur_digit_s = (idx_r == IW'(k)) ? snap_r[4*k +: 4] : cur_digit_s;
            cur_dp_s    = (idx_r == IW'(k)) ? dp_snap_r[k] : cur_dp_s;
            cur_blank_s = (idx_r == IW'(k)) ? (blank_lz & zero_run_s & (k != 0)) : cur_blank_s;
        end
    end

    // Prescaler, scan index, frame snapshot and registered display outputs.
    always_ff @(posedge clk) begin
        if (r) begin
            cnt_r     <= '0;
            idx_r     <= '0;
            snap_r    <= '0;
            dp_snap_r <= '0;
            an_r      <= {DIGITS{1'b1}};
            seg_r     <= 7'h7F;
            dp_r      <= 1'b1;
            frame_r   <= 1'b0;
        end else begin
            if (tick_s) begin
                cnt_r <= '0;
                idx_r <= last_s ? '0 : idx_r + IW'(1);
            end else begin
                cnt_r <= cnt_r + CW'(1);
                idx_r <= idx_r;
            end
            if (tick_s && last_s) begin
                snap_r    <= bcd_in;
                dp_snap_r <= dp_in;
            end else begin
                snap_r    <= snap_r;
                dp_snap_r <= dp_snap_r;
            end
            frame_r <= tick_s & last_s;
            an_r    <= an_s;
            seg_r   <= cur_blank_s ? 7'h7F : ~seg7_decode(cur_digit_s);
            dp_r    <= ~cur_dp_s;
        end
    end

    assign an    = an_r;
    assign seg   = seg_r;
    assign dp    = dp_r;
    assign frame = frame_r;

endmodule
